// File: rtl/wide_add_seq.sv
`default_nettype none
// wide_add_seq: WORDS x 32-bit add/subtract, one word per cycle, LS word first, through one csa32.
// Revision: 1.0

module csa32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [16:0] w_lo;
  logic [16:0] w_hi0;
  logic [16:0] w_hi1;

  // The upper half is precomputed for both incoming carries and then selected.
  assign w_lo  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin};
  assign w_hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
  assign w_hi1 = w_hi0 + 17'd1;
  assign sum   = {(w_lo[16] ? w_hi1[15:0] : w_hi0[15:0]), w_lo[15:0]};
  assign cout  = w_lo[16] ? w_hi1[16] : w_hi0[16];
endmodule

module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  abort,
  input  logic [32*WORDS-1:0]   a_in,
  input  logic [32*WORDS-1:0]   b_in,
  output logic                  ready,
  output logic                  done,
  output logic [32*WORDS-1:0]   result,
  output logic                  cout,
  output logic                  ovf
);
  localparam int W  = 32 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [31:0]     w_sum;
  logic            w_cout;
  logic            w_last;

  // Operand copies shift right each cycle, so the active word is always bits [31:0].
  csa32 u_csa32 (
    .a    (r_a[31:0]),
    .b    (r_b[31:0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_last = (r_idx == IW'(WORDS - 1));
  assign ready  = (r_state == S_IDLE);
  assign done   = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (abort) w_next = S_IDLE;
               else if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= sub ? ~b_in : b_in;
            r_carry <= sub;
            r_idx   <= '0;
            result  <= '0;
          end
        end
        S_RUN: begin
          // An abort leaves the word in flight unwritten.
          if (!abort) begin
            result[r_idx*32 +: 32] <= w_sum;
            r_carry <= w_cout;
            r_idx   <= r_idx + 1'b1;
            r_a     <= r_a >> 32;
            r_b     <= r_b >> 32;
            if (w_last) begin
              cout <= w_cout;
              ovf  <= (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire
